// File: rtl/sle_readback.sv
// Serial readback for SLE register banks: snapshots a parallel bank on request and
// streams it LSB-first over a valid/ready handshake, with an optional even-parity trailer.
module sle_readback #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PARITY = 1
) (
  input  logic             clk,
  input  logic             aln,
  input  logic             req,
  input  logic [WIDTH-1:0] par_in,
  output logic             sdo,
  output logic             sdo_valid,
  input  logic             sdo_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + PARITY + 1);
  localparam logic [CntW-1:0] DataBeats = CntW'(WIDTH);
  localparam logic [CntW-1:0] LastBeat  = CntW'(WIDTH + PARITY - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             parity_q, parity_d;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d  = StShift;
          shadow_d = par_in;
          cnt_d    = '0;
          parity_d = ^par_in;
        end
      end
      StShift: begin
        if (sdo_ready) begin
          shadow_d = {1'b0, shadow_q[WIDTH-1:1]};
          if (cnt_q == LastBeat) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge aln) begin
    if (!aln) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
    end
  end

  // Outputs decode registered state only, so sdo_ready never reaches sdo/sdo_valid.
  always_comb begin
    sdo_valid = (state_q == StShift);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    sdo       = 1'b0;
    if (sdo_valid) begin
      sdo = (cnt_q < DataBeats) ? shadow_q[0] : parity_q;
    end
  end

endmodule

// File: tb/tb_sle_readback.sv
// Directed self-checking bench for sle_readback: a WIDTH=8/PARITY=1 instance and a
// WIDTH=4/PARITY=0 instance sharing clock and reset.
module tb_sle_readback;

  logic       clk;
  logic       aln;
  logic       req;
  logic [7:0] par_in;
  logic       sdo;
  logic       sdo_valid;
  logic       sdo_ready;
  logic       busy;
  logic       done;

  logic       b_req;
  logic [3:0] b_par_in;
  logic       b_sdo;
  logic       b_sdo_valid;
  logic       b_sdo_ready;
  logic       b_busy;
  logic       b_done;

  int n_checks = 0;
  int n_fail   = 0;

  sle_readback #(.WIDTH(8), .PARITY(1)) u_dut (
    .clk       (clk),
    .aln       (aln),
    .req       (req),
    .par_in    (par_in),
    .sdo       (sdo),
    .sdo_valid (sdo_valid),
    .sdo_ready (sdo_ready),
    .busy      (busy),
    .done      (done)
  );

  sle_readback #(.WIDTH(4), .PARITY(0)) u_dut_np (
    .clk       (clk),
    .aln       (aln),
    .req       (b_req),
    .par_in    (b_par_in),
    .sdo       (b_sdo),
    .sdo_valid (b_sdo_valid),
    .sdo_ready (b_sdo_ready),
    .busy      (b_busy),
    .done      (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one stream on the 8-bit instance. Called at a negedge; returns at the first
  // IDLE negedge. exp holds the hand-computed beats (bit k = beat k, bit 8 = parity).
  task automatic stream_a(input string tag, input logic [7:0] cap, input logic [7:0] later,
                          input logic [8:0] exp, input logic [31:0] rpat, input bit hold_req,
                          input int exp_done_i);
    int   k          = 0;
    bit   seen_done  = 0;
    logic prev_stall = 1'b0;
    logic prev_sdo   = 1'b0;
    par_in = cap;
    req    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold_req) req = 1'b0;
    par_in = later;
    check({tag, "_first_valid"}, {31'd0, sdo_valid}, 32'd1);
    check({tag, "_first_busy"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < 80 && !seen_done; i++) begin
      if (done) begin
        seen_done = 1;
        check({tag, "_beats_at_done"}, k, 32'd9);
        if (exp_done_i >= 0) check({tag, "_done_cycle"}, i, exp_done_i);
        check({tag, "_done_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_done_valid"}, {30'd0, sdo_valid, sdo}, 32'd0);
      end else begin
        if (prev_stall) begin
          check($sformatf("%s_hold%0d", tag, k), {30'd0, sdo_valid, sdo}, {30'd0, 1'b1, prev_sdo});
        end
        sdo_ready = rpat[i % 32];
        if (sdo_valid && sdo_ready) begin
          if (k < 9) check($sformatf("%s_beat%0d", tag, k), {31'd0, sdo}, {31'd0, exp[k]});
          k++;
        end
        prev_stall = sdo_valid && !sdo_ready;
        prev_sdo   = sdo;
        @(negedge clk);
      end
    end
    if (!seen_done) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    check({tag, "_idle_outs"}, {28'd0, done, busy, sdo_valid, sdo}, 32'd0);
    sdo_ready = 1'b1;
  endtask

  initial begin
    int   k;
    bit   seen;
    logic [3:0] b_exp;

    aln         = 1'b0;
    req         = 1'b0;
    par_in      = 8'h00;
    sdo_ready   = 1'b1;
    b_req       = 1'b0;
    b_par_in    = 4'h0;
    b_sdo_ready = 1'b1;
    #1;
    check("reset_outs", {28'd0, done, busy, sdo_valid, sdo}, 32'd0);
    check("reset_outs_np", {28'd0, b_done, b_busy, b_sdo_valid, b_sdo}, 32'd0);
    repeat (2) @(negedge clk);
    aln = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {28'd0, done, busy, sdo_valid, sdo}, 32'd0);

    // A5 -> 1,0,1,0,0,1,0,1 then parity 0
    stream_a("nominal", 8'hA5, 8'hA5, 9'b0_1010_0101, 32'hFFFF_FFFF, 1'b0, 9);
    // 07 -> 1,1,1,0,0,0,0,0 then parity 1; bank changes to FF after capture
    stream_a("isolate", 8'h07, 8'hFF, 9'b1_0000_0111, 32'hFFFF_FFFF, 1'b0, 9);
    // 3C -> 0,0,1,1,1,1,0,0 then parity 0, under backpressure (1,0,0,1,...)
    stream_a("bp", 8'h3C, 8'h3C, 9'b0_0011_1100, 32'h6B3D_4C59, 1'b0, -1);
    // req held from capture through DONE: C3 stream once, then 5A captured in IDLE
    stream_a("busyreq1", 8'hC3, 8'h5A, 9'b0_1100_0011, 32'hFFFF_FFFF, 1'b1, 9);
    stream_a("busyreq2", 8'h5A, 8'h5A, 9'b0_0101_1010, 32'hFFFF_FFFF, 1'b0, 9);

    // Asynchronous reset after three accepted beats of an E6 stream.
    par_in    = 8'hE6;
    sdo_ready = 1'b1;
    req       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_valid", {31'd0, sdo_valid}, 32'd1);
    check("rst_pre_sdo", {31'd0, sdo}, 32'd0);
    #2;
    aln = 1'b0;
    #1;
    check("rst_async_outs", {28'd0, done, busy, sdo_valid, sdo}, 32'd0);
    @(negedge clk);
    check("rst_held_outs", {28'd0, done, busy, sdo_valid, sdo}, 32'd0);
    aln = 1'b1;
    @(negedge clk);
    check("rst_release_idle", {28'd0, done, busy, sdo_valid, sdo}, 32'd0);
    // 81 -> 1,0,0,0,0,0,0,1 then parity 0
    stream_a("after_rst", 8'h81, 8'h81, 9'b0_1000_0001, 32'hFFFF_FFFF, 1'b0, 9);

    // PARITY=0 build: B -> 1,1,0,1, four beats.
    b_exp       = 4'b1011;
    b_par_in    = 4'hB;
    b_sdo_ready = 1'b1;
    b_req       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_req = 1'b0;
    k     = 0;
    seen  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (b_done) begin
        seen = 1;
        check("np_beats_at_done", k, 32'd4);
        check("np_done_cycle", i, 32'd4);
        check("np_done_busy", {31'd0, b_busy}, 32'd1);
      end else begin
        if (b_sdo_valid) begin
          if (k < 4) check($sformatf("np_beat%0d", k), {31'd0, b_sdo}, {31'd0, b_exp[k]});
          k++;
        end
        @(negedge clk);
      end
    end
    if (!seen) check("np_done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("np_idle_outs", {28'd0, b_done, b_busy, b_sdo_valid, b_sdo}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
